sync_fifo_flex: RTL and testbench

- Parametrised single-clock FIFO; successor to the team's dual-clock FIFO for same-domain buffering.
- Adds over the dual-clock FIFO:
  - configurable width and depth
  - programmable almost-full / almost-empty thresholds
  - fill count
  - sticky overflow/underflow error flags
- Optional first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer sharing clk, e.g. packet staging ahead of the dual-clock crossing.

---
 rtl/sync_fifo_flex.sv | 159 +++++++++++++++
 tb/tb_sync_fifo_flex.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with fill count,
// programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. All outputs are registered.
//
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// mode: a one-word output register in front of the RAM always holds the
// head word, so data_out is valid whenever fifo_empty=0. Without the macro
// the FIFO reads with one cycle of latency (data_out updates on a read).
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flex: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of two >= 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_ram_we;
  logic                  w_ram_re;
`ifdef SYNC_FIFO_FWFT_EN
  logic                  w_out_free;
  logic                  w_ram_has;
  logic                  w_bypass;
`endif

  // Accept decisions, next fill count and RAM port enables.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_rd_ok     = rd_en && !r_empty;
    w_wr_ok     = wr_en && (!r_full || w_rd_ok);
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
`ifdef SYNC_FIFO_FWFT_EN
    // The output register counts as one stored word; the RAM holds the rest.
    // The output slot is refilled from the RAM when it has words, otherwise
    // straight from data_in so a write to an empty FIFO shows up next cycle.
    w_out_free = r_empty || w_rd_ok;
    w_ram_has  = r_count > CNT_ONE;
    w_bypass   = w_out_free && !w_ram_has && w_wr_ok;
    w_ram_re   = w_out_free && w_ram_has;
    w_ram_we   = w_wr_ok && !w_bypass;
`else
    w_ram_re   = w_rd_ok;
    w_ram_we   = w_wr_ok;
`endif
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately left out of reset; stale words are
    // unreachable once the pointers and count are cleared.
    if (w_ram_we) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, read data, fill count and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_ram_we) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_ram_re) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      end
`ifdef SYNC_FIFO_FWFT_EN
      else if (w_bypass) begin
        r_data_out <= data_in;
      end
`endif
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AFULL_C);
      r_aempty <= (w_count_nxt <= AEMPTY_C);
      // Sticky errors: a new event in the clearing cycle keeps the flag set.
      r_ovf    <= (r_ovf && !clr_err) || (wr_en && !w_wr_ok);
      r_udf    <= (r_udf && !clr_err) || (rd_en && !w_rd_ok);
    end
  end

  assign data_out     = r_data_out;
  assign fifo_full    = r_full;
  assign fifo_empty   = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign fill_count   = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: self-checking bench for sync_fifo_flex (DEPTH=16,
// DATA_WIDTH=8). A queue-based reference model predicts every output each
// cycle; a vector table and directed sequences add explicit expectations.
module tb_sync_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    fill_count;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic          clr;
    logic [4:0]    fill;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t tbl [13];

  // Reference model state: stored words in order, presented word, error flags.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the FIFO's architectural rules.
  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic c, input logic rst);
    int  sz;
    bit  rd_ok;
    bit  wr_ok;
    if (!rst) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      sz    = mq.size();
      rd_ok = r && (sz > 0);
      wr_ok = w && ((sz < DEPTH) || rd_ok);
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_udf = (m_udf && !c) || (r && !rd_ok);
`ifdef SYNC_FIFO_FWFT_EN
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
      if (mq.size() > 0) m_dout = mq[0];
`else
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(d);
`endif
    end
  endtask

  function automatic logic [31:0] model_vec();
    int sz;
    sz = mq.size();
    return {13'b0, m_dout, 5'(sz), (sz == 0), (sz == DEPTH), (sz >= AF), (sz <= AE),
            m_ovf, m_udf};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {13'b0, data_out, fill_count, fifo_empty, fifo_full, almost_full, almost_empty,
            overflow, underflow};
  endfunction

  // Apply one cycle of stimulus, update the model at the edge, compare 1ns later.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rst = 1'b1);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    clr_err = c;
    rst_n   = rst;
    @(posedge clk);
    model_edge(w, d, r, c, rst);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  initial begin
    wr_en   = 1'b0;
    data_in = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst_n   = 1'b0;
    mq.delete();
    m_dout  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;

    //           wr    din    rd    clr   fill  emp   full  ovf   udf
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset then idle three cycles.
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("idle_status", {24'b0, fill_count, fifo_empty, almost_empty, overflow},
            {24'b0, 5'd0, 1'b1, 1'b1, 1'b0});
      check("idle_dout", {24'b0, data_out}, 32'h0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
      check($sformatf("vec%0d", i),
            {23'b0, fill_count, fifo_empty, fifo_full, overflow, underflow},
            {23'b0, tbl[i].fill, tbl[i].empty, tbl[i].full, tbl[i].ovf, tbl[i].udf});
    end

    // Fill to full, thresholds, overflow.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 13) check("afull_13", {31'b0, almost_full}, 32'd0);
      if (i == 14) check("afull_14", {31'b0, almost_full}, 32'd1);
      if (i == 15) check("full_15", {31'b0, fifo_full}, 32'd0);
    end
    check("full_16", {26'b0, fifo_full, fill_count}, {26'b0, 1'b1, 5'd16});
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("ovf_17", {26'b0, overflow, fill_count}, {26'b0, 1'b1, 5'd16});
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", {31'b0, overflow}, 32'd0);

    // Simultaneous read/write while full.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_rw", {26'b0, overflow, fill_count}, {26'b0, 1'b0, 5'd16});
`ifdef SYNC_FIFO_FWFT_EN
    check("full_rw_dout", {24'b0, data_out}, 32'h02);
`else
    check("full_rw_dout", {24'b0, data_out}, 32'h01);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      if (i == 14) check("drain_last", {24'b0, data_out}, 32'hAA);
`else
      if (i == 15) check("drain_last", {24'b0, data_out}, 32'hAA);
`endif
    end
    check("drained", {27'b0, fifo_empty, fill_count}, {27'b0, 1'b1, 5'd0});

    // Interleaved write/read across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      check("wrap_order", {24'b0, data_out}, 32'(i));
`endif
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("wrap_order", {24'b0, data_out}, 32'(i));
`endif
    end
    check("wrap_flags", {30'b0, overflow, underflow}, 32'd0);

    // Read on empty, clear, clear racing a new error.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", {23'b0, underflow, data_out}, {23'b0, 1'b1, 8'h13});
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("udf_clr", {31'b0, underflow}, 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("udf_set_wins", {31'b0, underflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation with five words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check("midrst", {26'b0, fifo_empty, fill_count}, {26'b0, 1'b1, 5'd0});
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("midrst_rd", {24'b0, data_out}, 32'h55);

`ifdef SYNC_FIFO_FWFT_EN
    // First-word-fall-through presentation without rd_en.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("fwft_present", {23'b0, fifo_empty, data_out}, {23'b0, 1'b0, 8'h3C});
    step(1'b1, 8'h3D, 1'b1, 1'b0);
    check("fwft_1entry_rw", {23'b0, fifo_empty, data_out}, {23'b0, 1'b0, 8'h3D});
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Randomised traffic in write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 3000; i++) begin
      int wpct;
      int rpct;
      logic w;
      logic r;
      logic c;
      logic rst;
      wpct = (i < 1000) ? 75 : (i < 2000) ? 25 : 50;
      rpct = 100 - wpct;
      w    = ($urandom_range(0, 99) < wpct);
      r    = ($urandom_range(0, 99) < rpct);
      c    = ($urandom_range(0, 99) < 5);
      rst  = ($urandom_range(0, 999) >= 5);
      step(w, 8'($urandom), r, c, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
